// File: rtl/alu_beat_sequencer_pkg.sv
// Shared constants for the ALU beat sequencer: opcode encodings, beat
// indices, FSM state encoding and the opcode -> one-hot flag decoder.
package alu_ctrl_pkg;
  localparam int NUM_OPS = 11;

  localparam int OP_MOV = 0;
  localparam int OP_ADD = 1;
  localparam int OP_SUB = 2;
  localparam int OP_MUL = 3;
  localparam int OP_DIV = 4;
  localparam int OP_OR  = 5;
  localparam int OP_NOT = 6;
  localparam int OP_AND = 7;
  localparam int OP_XOR = 8;
  localparam int OP_SHL = 9;
  localparam int OP_SHR = 10;

  localparam int BEAT_LD     = 0;
  localparam int BEAT_DLATCH = 3;
  localparam int BEAT_DCALC  = 5;
  localparam int BEAT_LO     = 6;
  localparam int BEAT_HI     = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One-hot op select; out-of-range opcodes decode to all zero.
  function automatic logic [NUM_OPS-1:0] op_decode(input int op);
    logic [NUM_OPS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_OPS; i++) v[i] = (op == i);
    return v;
  endfunction
endpackage

// File: rtl/alu_beat_sequencer_if.sv
// Control bundle between a requester and the beat sequencer.
// master: drives start/opcode, observes status, beats and ALU controls.
// slave : the sequencer side.
interface alu_beat_sequencer_if #(parameter int OPW = 4);
  logic           start;
  logic [OPW-1:0] opcode;
  logic           busy, done, err;
  logic [7:0]     T;
  logic           IMOV, IADD, ISUB, IMUL, IDIV, IOR, INOT, IAND, IXOR, ISHL, ISHR;
  logic           EALU, ld_ab, wr_lo, wr_hi;

  modport master (
    output start, opcode,
    input  busy, done, err, T,
    input  IMOV, IADD, ISUB, IMUL, IDIV, IOR, INOT, IAND, IXOR, ISHL, ISHR,
    input  EALU, ld_ab, wr_lo, wr_hi
  );

  modport slave (
    input  start, opcode,
    output busy, done, err, T,
    output IMOV, IADD, ISUB, IMUL, IDIV, IOR, INOT, IAND, IXOR, ISHL, ISHR,
    output EALU, ld_ab, wr_lo, wr_hi
  );
endinterface

// File: rtl/alu_beat_sequencer_beat_ring.sv
// beat_ring: 8-bit one-hot beat register.
// Ports: clk, rst (sync, high); i_clr clears, i_load sets T0, i_adv shifts
// the hot bit up one beat; o_t is the beat bus. Priority: clr > load > adv.
module beat_ring (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic       i_adv,
  output logic [7:0] o_t
);
  logic [7:0] r_t;

  always_ff @(posedge clk) begin
    if (rst || i_clr)  r_t <= '0;
    else if (i_load)   r_t <= 8'h01;
    else if (i_adv)    r_t <= {r_t[6:0], 1'b0};
  end

  assign o_t = r_t;
endmodule

// File: rtl/alu_beat_sequencer.sv
// alu_beat_sequencer: timing/control stage ahead of the 8-bit ALU.
// Accepts one opcode per start, walks the one-hot beat bus T0..T6/T7 and
// drives op-select flags, EALU and register strobes, all registered.
// Ports: clk, rst (sync, high), bus (slave side of alu_beat_sequencer_if).
module alu_beat_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter bit SHORT_EXIT = 1'b1,
  parameter int OPW        = 4
) (
  input logic                  clk,
  input logic                  rst,
  alu_beat_sequencer_if.slave  bus
);
  state_t               r_state;
  logic [OPW-1:0]       r_op;
  logic [NUM_OPS-1:0]   r_flags;
  logic                 r_done, r_err, r_ealu, r_ld_ab, r_wr_lo, r_wr_hi;
  logic [7:0]           w_t, w_nxt;
  logic                 w_legal, w_accept, w_muldiv, w_last, w_run;

  assign w_run    = (r_state == ST_RUN);
  assign w_legal  = int'(bus.opcode) < NUM_OPS;
  assign w_accept = bus.start && !w_run && w_legal;
  assign w_muldiv = (r_op == OPW'(OP_MUL)) || (r_op == OPW'(OP_DIV));
  // MUL/DIV always need the T7 high-byte beat.
  assign w_last   = w_run && (w_t[BEAT_HI] ||
                    (SHORT_EXIT && w_t[BEAT_LO] && !w_muldiv));
  assign w_nxt    = {w_t[6:0], 1'b0};

  beat_ring u_ring (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_last),
    .i_load (w_accept),
    .i_adv  (w_run && !w_last),
    .o_t    (w_t)
  );

  // Strobes are registered against the beat about to appear (w_nxt) so
  // they line up with T on the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ealu  <= 1'b0;
      r_ld_ab <= 1'b0;
      r_wr_lo <= 1'b0;
      r_wr_hi <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_RUN: begin
          r_ld_ab <= 1'b0;
          if (w_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_flags <= '0;
            r_ealu  <= 1'b0;
            r_wr_lo <= 1'b0;
            r_wr_hi <= 1'b0;
          end else begin
            r_ealu  <= w_nxt[BEAT_LO] | (w_nxt[BEAT_HI] & w_muldiv);
            r_wr_lo <= w_nxt[BEAT_LO];
            r_wr_hi <= w_nxt[BEAT_HI] & w_muldiv;
          end
        end
        default: begin // IDLE and DONE both accept a new request
          r_state <= ST_IDLE;
          if (bus.start) begin
            if (w_legal) begin
              r_state <= ST_RUN;
              r_op    <= bus.opcode;
              r_flags <= op_decode(int'(bus.opcode));
              r_ld_ab <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.T     = w_t;
  assign bus.busy  = |w_t;
  assign bus.done  = r_done;
  assign bus.err   = r_err;
  assign bus.EALU  = r_ealu;
  assign bus.ld_ab = r_ld_ab;
  assign bus.wr_lo = r_wr_lo;
  assign bus.wr_hi = r_wr_hi;
  assign bus.IMOV  = r_flags[OP_MOV];
  assign bus.IADD  = r_flags[OP_ADD];
  assign bus.ISUB  = r_flags[OP_SUB];
  assign bus.IMUL  = r_flags[OP_MUL];
  assign bus.IDIV  = r_flags[OP_DIV];
  assign bus.IOR   = r_flags[OP_OR];
  assign bus.INOT  = r_flags[OP_NOT];
  assign bus.IAND  = r_flags[OP_AND];
  assign bus.IXOR  = r_flags[OP_XOR];
  assign bus.ISHL  = r_flags[OP_SHL];
  assign bus.ISHR  = r_flags[OP_SHR];
endmodule

// File: tb/tb_alu_beat_sequencer.sv
// Self-checking bench for alu_beat_sequencer (SHORT_EXIT=1). Expected
// per-cycle outputs are queued when a request is driven and popped as the
// DUT steps; a small ALU model checks the data bus on MUL/DIV.
module tb_alu_beat_sequencer;
  localparam bit SE = 1'b1;

  typedef struct packed {
    logic        busy, done, err;
    logic [7:0]  t;
    logic [10:0] fl;
    logic        ealu, ld, wlo, whi;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_beat_sequencer_if #(.OPW(4)) bus ();

  alu_beat_sequencer #(.SHORT_EXIT(SE), .OPW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  obs_t w_obs;
  assign w_obs = {bus.busy, bus.done, bus.err, bus.T,
                  bus.ISHR, bus.ISHL, bus.IXOR, bus.IAND, bus.INOT, bus.IOR,
                  bus.IDIV, bus.IMUL, bus.ISUB, bus.IADD, bus.IMOV,
                  bus.EALU, bus.ld_ab, bus.wr_lo, bus.wr_hi};

  // Attached ALU: A/B operands (B doubles as dividend high byte), divisor.
  logic [7:0]  a, b, dvs, alu_bus;
  logic [15:0] prod, dvd;
  always_comb begin
    alu_bus = 8'h00;
    prod    = {8'h00, a} * {8'h00, b};
    dvd     = {b, a};
    if (bus.EALU) begin
      if (bus.IMUL)
        alu_bus = bus.T[7] ? prod[15:8] : prod[7:0];
      else if (bus.IDIV && dvs != 8'h00)
        alu_bus = bus.T[7] ? 8'(dvd % {8'h00, dvs}) : 8'(dvd / {8'h00, dvs});
    end
  end

  obs_t       sb[$];
  logic [7:0] sb_bus[$];
  int n_chk = 0, n_fail = 0;

  // Queue the expected cycle-by-cycle outputs of one legal operation.
  task automatic push_run(input int op);
    bit md;
    int last;
    obs_t e;
    md   = (op == 3) || (op == 4);
    last = (md || !SE) ? 7 : 6;
    for (int k = 0; k <= last; k++) begin
      e      = '0;
      e.busy = 1'b1;
      e.t    = 8'(1 << k);
      e.fl   = 11'(1 << op);
      e.ld   = (k == 0);
      e.wlo  = (k == 6);
      e.whi  = (k == 7) && md;
      e.ealu = (k == 6) || ((k == 7) && md);
      sb.push_back(e);
    end
    e      = '0;
    e.done = 1'b1;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.opcode = '0;
    a = 8'h00; b = 8'h00; dvs = 8'h00;
    rst = 1'b1;
    step(); step();
    n_chk++;
    if (w_obs !== obs_t'(0)) begin
      n_fail++; $display("FAIL reset got=%h exp=%h", w_obs, obs_t'(0));
    end
    rst = 1'b0;
    step();
    n_chk++;
    if (w_obs !== obs_t'(0)) begin
      n_fail++; $display("FAIL idle_after_reset got=%h exp=%h", w_obs, obs_t'(0));
    end
  endtask

  task automatic test_add();
    obs_t e;
    int c;
    bus.opcode = 4'd1; bus.start = 1'b1;
    push_run(1);
    sb.push_back('0);
    step();
    bus.start = 1'b0;
    c = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if (w_obs !== e) begin
        n_fail++; $display("FAIL add cyc%0d got=%h exp=%h", c, w_obs, e);
      end
      step(); c++;
    end
  endtask

  task automatic test_mul();
    obs_t e;
    int c;
    a = 8'h12; b = 8'h34;
    sb_bus.push_back(8'hA8); sb_bus.push_back(8'h03);
    bus.opcode = 4'd3; bus.start = 1'b1;
    push_run(3);
    step();
    bus.start = 1'b0;
    c = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if (w_obs !== e) begin
        n_fail++; $display("FAIL mul cyc%0d got=%h exp=%h", c, w_obs, e);
      end
      if (bus.EALU) begin
        n_chk++;
        if (sb_bus.size() == 0) begin
          n_fail++; $display("FAIL mul_bus cyc%0d got=%h exp=none", c, alu_bus);
        end else if (alu_bus !== sb_bus[0]) begin
          n_fail++; $display("FAIL mul_bus cyc%0d got=%h exp=%h", c, alu_bus, sb_bus[0]);
          void'(sb_bus.pop_front());
        end else void'(sb_bus.pop_front());
      end
      step(); c++;
    end
    n_chk++;
    if (sb_bus.size() != 0) begin
      n_fail++; $display("FAIL mul_bus_left got=%0d exp=0", sb_bus.size());
      sb_bus.delete();
    end
  endtask

  task automatic test_div();
    obs_t e;
    int c;
    a = 8'h07; b = 8'h00; dvs = 8'h03;
    sb_bus.push_back(8'h02); sb_bus.push_back(8'h01);
    bus.opcode = 4'd4; bus.start = 1'b1;
    push_run(4);
    step();
    bus.start = 1'b0;
    c = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if (w_obs !== e) begin
        n_fail++; $display("FAIL div cyc%0d got=%h exp=%h", c, w_obs, e);
      end
      if (bus.EALU) begin
        n_chk++;
        if (sb_bus.size() == 0) begin
          n_fail++; $display("FAIL div_bus cyc%0d got=%h exp=none", c, alu_bus);
        end else if (alu_bus !== sb_bus[0]) begin
          n_fail++; $display("FAIL div_bus cyc%0d got=%h exp=%h", c, alu_bus, sb_bus[0]);
          void'(sb_bus.pop_front());
        end else void'(sb_bus.pop_front());
      end
      step(); c++;
    end
    n_chk++;
    if (sb_bus.size() != 0) begin
      n_fail++; $display("FAIL div_bus_left got=%0d exp=0", sb_bus.size());
      sb_bus.delete();
    end
  endtask

  // start held through two whole SUB runs: the second T0 must follow the
  // first done directly, and start seen during RUN must not restart T.
  task automatic test_back_to_back();
    obs_t e;
    int c;
    bus.opcode = 4'd2; bus.start = 1'b1;
    push_run(2);
    push_run(2);
    step();
    c = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if (w_obs !== e) begin
        n_fail++; $display("FAIL b2b cyc%0d got=%h exp=%h", c, w_obs, e);
      end
      if (sb.size() == 0) bus.start = 1'b0;
      step(); c++;
    end
    n_chk++;
    if (w_obs !== obs_t'(0)) begin
      n_fail++; $display("FAIL b2b_idle got=%h exp=%h", w_obs, obs_t'(0));
    end
  endtask

  task automatic test_illegal();
    obs_t e;
    int c;
    e = '0; e.err = 1'b1;
    sb.push_back(e);
    sb.push_back('0);
    sb.push_back('0);
    bus.opcode = 4'hC; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    c = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if (w_obs !== e) begin
        n_fail++; $display("FAIL illegal cyc%0d got=%h exp=%h", c, w_obs, e);
      end
      step(); c++;
    end
  endtask

  task automatic test_reset_mid_run();
    obs_t e;
    bus.opcode = 4'd4; bus.start = 1'b1;
    push_run(4);
    step();
    bus.start = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      e = sb.pop_front();
      n_chk++;
      if (w_obs !== e) begin
        n_fail++; $display("FAIL rstrun T%0d got=%h exp=%h", k, w_obs, e);
      end
      if (k < 4) step();
    end
    sb.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++;
    if (w_obs !== obs_t'(0)) begin
      n_fail++; $display("FAIL rstrun_clear got=%h exp=%h", w_obs, obs_t'(0));
    end
    step();
    n_chk++;
    if (w_obs !== obs_t'(0)) begin
      n_fail++; $display("FAIL rstrun_nodone got=%h exp=%h", w_obs, obs_t'(0));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_back_to_back();
    test_illegal();
    test_reset_mid_run();
    test_add();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
